// File: rtl/enemy_wave_scheduler.sv
// enemy_wave_scheduler
// Central controller for the enemy slots of the falling-enemy game. It paces
// descent from the video frame tick, spawns enemies into free slots at
// pseudo-random lanes, and retires enemies on collision (score) or when they
// reach the bottom of the screen (life lost). When lives run out it parks in
// OVER until the next start pulse.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      one-cycle pulse, begins (IDLE) or restarts (OVER) the game
//   frame_tick one-cycle pulse per video frame
//   collision  per-slot hit flags, level-sampled every cycle
//   enemy_x    packed x per slot, slot i at bits [10i+9:10i]
//   enemy_y    packed y per slot, same packing
//   exists     slot-active flags
//   score      kill count, saturating at 65535
//   lives      remaining lives
//   game_over  high while in OVER
//   busy       high while stepping slots or spawning
module enemy_wave_scheduler #(
    parameter int NUM_ENEMIES = 4,
    parameter int STEP_PX     = 10,
    parameter int SCREEN_H    = 480,
    parameter int MOVE_DIV    = 2,
    parameter int SPAWN_STEPS = 8,
    parameter int LIVES       = 3,
    parameter int LANE_X0     = 64,
    parameter int LANE_W      = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      frame_tick,
    input  logic [NUM_ENEMIES-1:0]    collision,
    output logic [10*NUM_ENEMIES-1:0] enemy_x,
    output logic [10*NUM_ENEMIES-1:0] enemy_y,
    output logic [NUM_ENEMIES-1:0]    exists,
    output logic [15:0]               score,
    output logic [3:0]                lives,
    output logic                      game_over,
    output logic                      busy
);
    localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam int MV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int SP_W  = (SPAWN_STEPS > 1) ? $clog2(SPAWN_STEPS) : 1;
    localparam int CNT_W = $clog2(NUM_ENEMIES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_SPAWN,
        S_OVER
    } state_t;

    state_t               state_reg, state_next;
    logic [9:0]           x_reg [NUM_ENEMIES];
    logic [9:0]           x_next [NUM_ENEMIES];
    logic [9:0]           y_reg [NUM_ENEMIES];
    logic [9:0]           y_next [NUM_ENEMIES];
    logic [NUM_ENEMIES-1:0] exists_reg, exists_next;
    logic [15:0]          score_reg, score_next;
    logic [3:0]           lives_reg, lives_next;
    logic [MV_W-1:0]      move_cnt_reg, move_cnt_next;
    logic [SP_W-1:0]      spawn_cnt_reg, spawn_cnt_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [7:0]           lfsr_reg, lfsr_next;

    logic [NUM_ENEMIES-1:0] kill_mask;
    logic [CNT_W-1:0]     kill_cnt;
    logic [16:0]          score_sum;
    logic [10:0]          y_sum;
    logic                 free_found;
    logic [IDX_W-1:0]     free_idx;
    logic [9:0]           spawn_x;

    // Only live slots can be hit; a hit on an empty slot (including one that
    // is being spawned this very cycle) is ignored.
    assign kill_mask = exists_reg & collision;
    assign spawn_x   = 10'(LANE_X0) + 10'(lfsr_reg[2:0]) * 10'(LANE_W);

    always_comb begin
        kill_cnt = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            kill_cnt = kill_cnt + CNT_W'(kill_mask[i]);
        end
        score_sum = {1'b0, score_reg} + 17'(kill_cnt);
    end

    // Lowest-index empty slot: scan downwards so the last hit wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
            if (!exists_reg[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        x_next         = x_reg;
        y_next         = y_reg;
        exists_next    = exists_reg;
        score_next     = score_reg;
        lives_next     = lives_reg;
        move_cnt_next  = move_cnt_reg;
        spawn_cnt_next = spawn_cnt_reg;
        idx_next       = idx_reg;
        y_sum          = '0;
        // Fibonacci LFSR, taps 8,6,5,4; free-runs in every state.
        lfsr_next      = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end

            S_RUN, S_STEP, S_SPAWN: begin
                if (lives_reg == 4'd0) begin
                    // The last life went on the previous cycle: abandon
                    // whatever was in flight and clear the board.
                    state_next  = S_OVER;
                    exists_next = '0;
                end else begin
                    for (int i = 0; i < NUM_ENEMIES; i++) begin
                        if (kill_mask[i]) begin
                            exists_next[i] = 1'b0;
                            y_next[i]      = '0;
                        end
                    end
                    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

                    case (state_reg)
                        S_RUN: begin
                            if (frame_tick) begin
                                if (move_cnt_reg == MV_W'(MOVE_DIV - 1)) begin
                                    move_cnt_next = '0;
                                    idx_next      = '0;
                                    state_next    = S_STEP;
                                end else begin
                                    move_cnt_next = move_cnt_reg + 1'b1;
                                end
                            end
                        end

                        S_STEP: begin
                            // A colliding slot is already killed above and
                            // must neither move nor escape.
                            if (exists_reg[idx_reg] && !collision[idx_reg]) begin
                                y_sum = {1'b0, y_reg[idx_reg]} + 11'(STEP_PX);
                                if (y_sum >= 11'(SCREEN_H)) begin
                                    exists_next[idx_reg] = 1'b0;
                                    y_next[idx_reg]      = '0;
                                    lives_next           = lives_reg - 4'd1;
                                end else begin
                                    y_next[idx_reg] = y_sum[9:0];
                                end
                            end
                            if (idx_reg == IDX_W'(NUM_ENEMIES - 1)) begin
                                if (spawn_cnt_reg == SP_W'(SPAWN_STEPS - 1)) begin
                                    spawn_cnt_next = '0;
                                    state_next     = S_SPAWN;
                                end else begin
                                    spawn_cnt_next = spawn_cnt_reg + 1'b1;
                                    state_next     = S_RUN;
                                end
                            end else begin
                                idx_next = idx_reg + 1'b1;
                            end
                        end

                        default: begin
                            // S_SPAWN: a full table simply skips this spawn.
                            if (free_found) begin
                                exists_next[free_idx] = 1'b1;
                                y_next[free_idx]      = '0;
                                x_next[free_idx]      = spawn_x;
                            end
                            state_next = S_RUN;
                        end
                    endcase
                end
            end

            S_OVER: begin
                exists_next = '0;
                if (start) begin
                    // Fresh game; the LFSR keeps running so lanes differ.
                    for (int i = 0; i < NUM_ENEMIES; i++) begin
                        x_next[i] = '0;
                        y_next[i] = '0;
                    end
                    score_next     = '0;
                    lives_next     = 4'(LIVES);
                    move_cnt_next  = '0;
                    spawn_cnt_next = '0;
                    idx_next       = '0;
                    state_next     = S_RUN;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                x_reg[i] <= '0;
                y_reg[i] <= '0;
            end
            exists_reg    <= '0;
            score_reg     <= '0;
            lives_reg     <= 4'(LIVES);
            move_cnt_reg  <= '0;
            spawn_cnt_reg <= '0;
            idx_reg       <= '0;
            lfsr_reg      <= 8'hA5;
        end else begin
            state_reg     <= state_next;
            x_reg         <= x_next;
            y_reg         <= y_next;
            exists_reg    <= exists_next;
            score_reg     <= score_next;
            lives_reg     <= lives_next;
            move_cnt_reg  <= move_cnt_next;
            spawn_cnt_reg <= spawn_cnt_next;
            idx_reg       <= idx_next;
            lfsr_reg      <= lfsr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_ENEMIES; gi++) begin : g_pack
            assign enemy_x[10*gi +: 10] = x_reg[gi];
            assign enemy_y[10*gi +: 10] = y_reg[gi];
        end
    endgenerate

    assign exists    = exists_reg;
    assign score     = score_reg;
    assign lives     = lives_reg;
    assign game_over = (state_reg == S_OVER);
    assign busy      = (state_reg == S_STEP) || (state_reg == S_SPAWN);

endmodule

// File: tb/tb_enemy_wave_scheduler.sv
// Bench for enemy_wave_scheduler: a table of game operations drives the DUT;
// a step-level game model pushes the expected board after each operation
// into a queue, which is popped and compared once the DUT has settled.
// Hand-derived checkpoints in the table and a few cycle-exact sequences
// (escape, full table, game over, reset mid-step) cover the corner cases.
module tb_enemy_wave_scheduler;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          frame_tick = 1'b0;
    logic [N-1:0]  collision = '0;
    logic [10*N-1:0] enemy_x, enemy_y;
    logic [N-1:0]  exists;
    logic [15:0]   score;
    logic [3:0]    lives;
    logic          game_over, busy;

    enemy_wave_scheduler #(
        .NUM_ENEMIES(4), .STEP_PX(10), .SCREEN_H(480), .MOVE_DIV(2),
        .SPAWN_STEPS(8), .LIVES(3), .LANE_X0(64), .LANE_W(64)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frame_tick(frame_tick),
        .collision(collision), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .exists(exists), .score(score), .lives(lives),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // Independent copy of the lane generator, stepped on the same edges.
    logic [7:0] m_lfsr;
    always @(posedge clk) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // ---------------- game model ----------------
    logic [N-1:0] m_exists;
    int  m_x [N];
    int  m_y [N];
    int  m_score, m_lives, m_move, m_spawn;
    bit  m_run, m_over;

    task automatic model_reset();
        m_exists = '0;
        for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; end
        m_score = 0; m_lives = 3; m_move = 0; m_spawn = 0;
        m_run = 0; m_over = 0;
    endtask

    task automatic model_kill(input logic [N-1:0] hit);
        for (int i = 0; i < N; i++) begin
            if (hit[i] && m_exists[i]) begin
                m_exists[i] = 1'b0;
                m_y[i] = 0;
                if (m_score < 65535) m_score++;
            end
        end
    endtask

    task automatic model_frame(input logic [N-1:0] hit, input logic [7:0] lf,
                               output bit stepped, output bit spawned);
        stepped = 0;
        spawned = 0;
        if (m_run && !m_over) begin
            model_kill(hit);
            if (m_move == 1) begin
                m_move = 0;
                stepped = 1;
                for (int i = 0; i < N; i++) begin
                    if (m_exists[i]) begin
                        if (m_y[i] + 10 >= 480) begin
                            m_exists[i] = 1'b0;
                            m_y[i] = 0;
                            m_lives--;
                            if (m_lives == 0) begin
                                m_over = 1;
                                break;
                            end
                        end else begin
                            m_y[i] += 10;
                        end
                    end
                end
                if (m_over) begin
                    m_exists = '0;
                end else if (m_spawn == 7) begin
                    m_spawn = 0;
                    spawned = 1;
                    for (int i = 0; i < N; i++) begin
                        if (!m_exists[i]) begin
                            m_exists[i] = 1'b1;
                            m_y[i] = 0;
                            m_x[i] = 64 + int'(lf[2:0]) * 64;
                            break;
                        end
                    end
                end else begin
                    m_spawn++;
                end
            end else begin
                m_move++;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [N-1:0]    exists;
        logic [10*N-1:0] x;
        logic [10*N-1:0] y;
        int              score;
        int              lives;
        bit              over;
        bit              chk_y;
    } exp_t;

    exp_t sb[$];

    task automatic push_model();
        exp_t e;
        e.exists = m_exists;
        for (int i = 0; i < N; i++) begin
            e.x[10*i +: 10] = 10'(m_x[i]);
            e.y[10*i +: 10] = 10'(m_y[i]);
        end
        e.score = m_score;
        e.lives = m_lives;
        e.over  = m_over;
        e.chk_y = !m_over;
        sb.push_back(e);
    endtask

    task automatic compare_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".exists"}, 64'(exists), 64'(e.exists));
            check({tag, ".score"}, 64'(score), 64'(e.score));
            check({tag, ".lives"}, 64'(lives), 64'(e.lives));
            check({tag, ".game_over"}, 64'(game_over), 64'(e.over));
            check({tag, ".busy"}, 64'(busy), 64'(0));
            check({tag, ".enemy_x"}, 64'(enemy_x), 64'(e.x));
            if (e.chk_y) check({tag, ".enemy_y"}, 64'(enemy_y), 64'(e.y));
        end
    endtask

    // ---------------- transactions ----------------
    // One frame occupies 8 edges: tick seen at E0, STEP on E1..E4, SPAWN
    // (if any) on E5. 'hit' is presented for the E1 edge (STEP slot 0).
    task automatic do_frame(input logic [N-1:0] hit, input bit full_chk,
                            input bit esc_chk, input bit over_chk);
        logic [7:0] lf = '0;
        logic [10*N-1:0] sx = '0;
        logic [10*N-1:0] sy = '0;
        bit stepped, spawned;
        int busy_cnt = 0;
        bit zero_seen = 0;
        bit over_done = 0;
        frame_tick = 1'b1;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin frame_tick = 1'b0; collision = hit; end
            if (e == 1) collision = '0;
            busy_cnt += int'(busy);
            if (e == 1 && esc_chk) begin
                check("escape.exists0", 64'(exists[0]), 64'(0));
                check("escape.lives", 64'(lives), 64'(2));
            end
            if (e == 4) begin lf = m_lfsr; sx = enemy_x; sy = enemy_y; end
            if (e == 5 && full_chk) begin
                check("full_spawn.x", 64'(enemy_x), 64'(sx));
                check("full_spawn.y", 64'(enemy_y), 64'(sy));
            end
            if (over_chk) begin
                if (zero_seen && !over_done) begin
                    check("over.game_over", 64'(game_over), 64'(1));
                    check("over.exists", 64'(exists), 64'(0));
                    over_done = 1;
                end else if (!zero_seen && lives == 4'd0) begin
                    zero_seen = 1;
                end
            end
        end
        if (over_chk && !over_done) begin
            checks++; errors++;
            $display("FAIL over.timeout: lives=%0d game_over=%0d never reached", lives, game_over);
        end
        model_frame(hit, lf, stepped, spawned);
        check("busy_cycles", 64'(busy_cnt), 64'(stepped ? (4 + int'(spawned)) : 0));
        push_model();
        compare_pop("frame");
    endtask

    task automatic do_hit(input logic [N-1:0] mask);
        collision = mask;
        @(posedge clk); #1;
        collision = '0;
        @(posedge clk); #1;
        if (m_run && !m_over) model_kill(mask);
        push_model();
        compare_pop("hit");
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        if (!m_run) begin
            m_run = 1;
        end else if (m_over) begin
            m_exists = '0;
            for (int i = 0; i < N; i++) begin m_x[i] = 0; m_y[i] = 0; end
            m_score = 0; m_lives = 3; m_move = 0; m_spawn = 0; m_over = 0;
        end
        push_model();
        compare_pop("start");
    endtask

    // rst sampled on the second STEP cycle (E2).
    task automatic do_rst_step();
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        check("rststep.busy_e0", 64'(busy), 64'(1));
        @(posedge clk); #1;
        check("rststep.busy_e1", 64'(busy), 64'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        push_model();
        compare_pop("rststep");
    endtask

    // ---------------- vector table ----------------
    typedef enum {OP_START, OP_FRAMES, OP_HITFRAME, OP_HIT, OP_FULL, OP_ESC, OP_OVER, OP_RSTSTEP} op_t;
    typedef struct {
        op_t          op;
        logic [N-1:0] mask;
        int           count;
        bit           chk;
        logic [N-1:0] exp_exists;
        int           exp_score;
        int           exp_lives;
        int           exp_y0;   // -1: not checked
    } vec_t;

    localparam int NV = 25;
    vec_t tbl [NV];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{OP_START,    4'b0000,  0, 1'b1, 4'b0000, 0, 3, -1};
        tbl[1]  = '{OP_FRAMES,   4'b0000, 15, 1'b1, 4'b0000, 0, 3, -1};
        tbl[2]  = '{OP_FRAMES,   4'b0000,  1, 1'b1, 4'b0001, 0, 3,  0};
        tbl[3]  = '{OP_FRAMES,   4'b0000, 20, 1'b1, 4'b0011, 0, 3, 100};
        tbl[4]  = '{OP_FRAMES,   4'b0000,  1, 1'b0, 4'b0000, 0, 0, -1};
        tbl[5]  = '{OP_HITFRAME, 4'b0001,  1, 1'b1, 4'b0010, 1, 3,  0};
        tbl[6]  = '{OP_FRAMES,   4'b0000, 26, 1'b1, 4'b0111, 1, 3, 80};
        tbl[7]  = '{OP_HIT,      4'b0101,  1, 1'b1, 4'b0010, 3, 3,  0};
        tbl[8]  = '{OP_HIT,      4'b0010,  1, 1'b1, 4'b0000, 4, 3,  0};
        tbl[9]  = '{OP_FRAMES,   4'b0000, 16, 1'b1, 4'b0001, 4, 3,  0};
        tbl[10] = '{OP_FRAMES,   4'b0000, 48, 1'b1, 4'b1111, 4, 3, 240};
        tbl[11] = '{OP_FRAMES,   4'b0000, 15, 1'b0, 4'b0000, 0, 0, -1};
        tbl[12] = '{OP_FULL,     4'b0000,  1, 1'b1, 4'b1111, 4, 3, 320};
        tbl[13] = '{OP_FRAMES,   4'b0000, 28, 1'b1, 4'b1111, 4, 3, 460};
        tbl[14] = '{OP_FRAMES,   4'b0000,  2, 1'b1, 4'b1111, 4, 3, 470};
        tbl[15] = '{OP_FRAMES,   4'b0000,  1, 1'b0, 4'b0000, 0, 0, -1};
        tbl[16] = '{OP_ESC,      4'b0000,  1, 1'b1, 4'b1111, 4, 2,  0};
        tbl[17] = '{OP_FRAMES,   4'b0000, 16, 1'b1, 4'b1111, 4, 1, 80};
        tbl[18] = '{OP_FRAMES,   4'b0000, 15, 1'b0, 4'b0000, 0, 0, -1};
        tbl[19] = '{OP_OVER,     4'b0000,  1, 1'b1, 4'b0000, 4, 0, -1};
        tbl[20] = '{OP_START,    4'b0000,  0, 1'b1, 4'b0000, 0, 3, -1};
        tbl[21] = '{OP_FRAMES,   4'b0000, 20, 1'b1, 4'b0001, 0, 3, 20};
        tbl[22] = '{OP_FRAMES,   4'b0000,  1, 1'b0, 4'b0000, 0, 0, -1};
        tbl[23] = '{OP_RSTSTEP,  4'b0000,  0, 1'b1, 4'b0000, 0, 3,  0};
        tbl[24] = '{OP_FRAMES,   4'b0000,  2, 1'b1, 4'b0000, 0, 3,  0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        push_model();
        compare_pop("reset");
        $display("txn reset: exists=%b score=%0d lives=%0d", exists, score, lives);

        for (int v = 0; v < NV; v++) begin
            case (tbl[v].op)
                OP_START:    do_start();
                OP_FRAMES:   for (int k = 0; k < tbl[v].count; k++) do_frame('0, 0, 0, 0);
                OP_HITFRAME: do_frame(tbl[v].mask, 0, 0, 0);
                OP_HIT:      do_hit(tbl[v].mask);
                OP_FULL:     do_frame('0, 1, 0, 0);
                OP_ESC:      do_frame('0, 0, 1, 0);
                OP_OVER:     do_frame('0, 0, 0, 1);
                default:     do_rst_step();
            endcase
            if (tbl[v].chk) begin
                check($sformatf("vec%0d.exists", v), 64'(exists), 64'(tbl[v].exp_exists));
                check($sformatf("vec%0d.score", v), 64'(score), 64'(tbl[v].exp_score));
                check($sformatf("vec%0d.lives", v), 64'(lives), 64'(tbl[v].exp_lives));
                if (tbl[v].exp_y0 >= 0)
                    check($sformatf("vec%0d.y0", v), 64'(enemy_y[9:0]), 64'(tbl[v].exp_y0));
            end
            $display("txn %0d op=%s exists=%b score=%0d lives=%0d over=%0d x0=%0d y0=%0d",
                     v, tbl[v].op.name(), exists, score, lives, game_over,
                     enemy_x[9:0], enemy_y[9:0]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
